stopwatch_time_state: RTL

Registered time-state stage of the stopwatch. It holds the current minutes/seconds and drives them to the next-time computation stage, which returns `next_seconds`/`next_minutes`. It generates the 1 Hz (run) and 2 Hz (adjust) advance ticks and owns the run/pause state machine. Its outputs also feed the display stage, including a blink enable for adjust mode.

---
 rtl/stopwatch_time_state_if.sv | 25 ++
 rtl/stopwatch_time_state.sv | 99 +++++++++
 2 files changed

// File: rtl/stopwatch_time_state_if.sv
// Signal bundle between the stopwatch time-state stage, its input conditioning,
// the next-time computation stage and the display stage.
interface stopwatch_time_state_if;
  logic [1:0] switches;
  logic       pause_pulse;
  logic       clear_pulse;
  logic [5:0] next_seconds;
  logic [5:0] next_minutes;
  logic [5:0] current_seconds;
  logic [5:0] current_minutes;
  logic [1:0] switches_sync;
  logic       paused;
  logic       blink;
  logic       tick;

  modport master (
    output switches, pause_pulse, clear_pulse, next_seconds, next_minutes,
    input  current_seconds, current_minutes, switches_sync, paused, blink, tick
  );

  modport slave (
    input  switches, pause_pulse, clear_pulse, next_seconds, next_minutes,
    output current_seconds, current_minutes, switches_sync, paused, blink, tick
  );
endinterface

// File: rtl/stopwatch_time_state.sv
// Stopwatch time-state stage: switch synchronizer, run/pause FSM, 1 Hz / 2 Hz
// advance divider, registered minutes/seconds and adjust-mode blink enable.
module stopwatch_time_state #(
  parameter int DIV_1HZ = 100000000
) (
  input  logic                 clk,
  input  logic                 rst,
  stopwatch_time_state_if.slave sw
);
  localparam int CNT_W = $clog2(DIV_1HZ);
  localparam logic [CNT_W-1:0] TERM_RUN = CNT_W'(DIV_1HZ - 1);
  localparam logic [CNT_W-1:0] TERM_ADJ = CNT_W'(DIV_1HZ / 2 - 1);

  typedef enum logic {S_RUN = 1'b0, S_PAUSE = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_paused;
  logic [1:0]       r_sw_p0;
  logic [1:0]       r_sw_p1;
  logic             r_adj_prev;
  logic [CNT_W-1:0] r_cnt;
  logic [5:0]       r_sec;
  logic [5:0]       r_min;
  logic             r_blink;
  logic             w_adj;
  logic             w_adj_chg;
  logic             w_counting;
  logic             w_terminal;
  logic             w_tick;

  function automatic logic [5:0] sat_time(input logic [5:0] v);
    return (v > 6'd59) ? 6'd0 : v;
  endfunction

  // Stage p0/p1: two-flop synchronizer on the raw slide switches
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sw_p0 <= 2'b00;
      r_sw_p1 <= 2'b00;
    end else begin
      r_sw_p0 <= sw.switches;
      r_sw_p1 <= r_sw_p0;
    end
  end

  assign w_adj      = r_sw_p1[1];
  assign w_adj_chg  = w_adj ^ r_adj_prev;
  assign w_counting = w_adj | (r_state == S_RUN);
  // >= so that a count left above the shorter adjust period still terminates
  assign w_terminal = r_cnt >= (w_adj ? TERM_ADJ : TERM_RUN);
  assign w_tick     = w_counting & w_terminal & ~w_adj_chg & ~sw.clear_pulse & ~rst;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_RUN;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_paused    = (r_state == S_PAUSE);
    if (sw.pause_pulse) w_state_nxt = (r_state == S_RUN) ? S_PAUSE : S_RUN;
  end

  // Divider: restarts on clear or on a mode change, holds while not counting
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_adj_prev <= 1'b0;
    end else begin
      r_adj_prev <= w_adj;
      if (sw.clear_pulse || w_adj_chg) r_cnt <= '0;
      else if (w_counting)             r_cnt <= w_terminal ? '0 : r_cnt + 1'b1;
    end
  end

  // Time register: loads the computation stage result on tick, out-of-range fields become 0
  always_ff @(posedge clk) begin
    if (rst || sw.clear_pulse) begin
      r_sec <= 6'd0;
      r_min <= 6'd0;
    end else if (w_tick) begin
      r_sec <= sat_time(sw.next_seconds);
      r_min <= sat_time(sw.next_minutes);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !w_adj) r_blink <= 1'b1;
    else if (w_tick)   r_blink <= ~r_blink;
  end

  assign sw.current_seconds = r_sec;
  assign sw.current_minutes = r_min;
  assign sw.switches_sync   = r_sw_p1;
  assign sw.paused          = w_paused;
  assign sw.blink           = r_blink | ~w_adj;
  assign sw.tick            = w_tick;
endmodule
